dl_sequencer: RTL and testbench

DL_SEQUENCER -- requirements
Module: dl_sequencer

---
 rtl/dl_pkg.sv | 17 +
 rtl/dl_fifo.sv | 64 ++++++
 rtl/dl_sequencer.sv | 122 ++++++++++++
 tb/tb_dl_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types and constants for the download sequencer.
// Stream indices, ROM address width and the packed FIFO entry width.
package dl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] IDX_ROM    = 8'd0;
  localparam logic [7:0] IDX_MOD    = 8'd1;
  localparam int         ROM_ADDR_W = 16;
  localparam int         ENTRY_W    = ROM_ADDR_W + 8;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous show-ahead FIFO of {addr, data} entries with full/empty flags.
// Also exposes the head as it will be after this edge, so a register can mirror it.
module dl_fifo
  import dl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic         nxt_vld,
  output logic [W-1:0] nxt_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx1;
  logic [W-1:0]  head;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign rd_idx    = rd_ptr[AW-1:0];
  assign rd_idx1   = rd_idx + AW'(1);
  assign head      = mem[rd_idx];
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign nxt_vld   = (count_nxt != '0);

  // A push into an empty (or just-emptied) FIFO becomes the new head directly.
  always_comb begin
    nxt_dat = head;
    if (pop) begin
      nxt_dat = (count > (AW+1)'(1)) ? mem[rd_idx1] : push_dat;
    end else if (empty) begin
      nxt_dat = push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/dl_sequencer.sv
// Buffers HPS download bytes into a ROM write port and sequences the game core reset
// (HOLD -> RUN, LOAD while downloading, DRAIN until the write buffer is empty).
module dl_sequencer
  import dl_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dn_download,
  input  logic [7:0]            dn_index,
  input  logic                  dn_wr,
  input  logic [24:0]           dn_addr,
  input  logic [7:0]            dn_data,
  input  logic                  rom_ready,
  output logic                  rom_wr,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic                  core_reset,
  output logic [7:0]            mod_sel,
  output logic                  overflow,
  output logic [16:0]           wr_count
);

  localparam int          CW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] WR_MAX = 17'h10000;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 dl_q;
  logic                 rise;
  logic                 fall;
  logic                 push_req;
  logic                 push_acc;
  logic                 pop;
  logic                 drop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 nxt_vld;
  logic [ENTRY_W-1:0]   nxt_dat;
  logic [7:0]           mod_q = 8'h00;

  assign rise     = dn_download & ~dl_q;
  assign fall     = ~dn_download & dl_q;
  assign push_req = dn_wr && (dn_index == IDX_ROM) && (dn_addr[24:16] == '0);
  assign pop      = rom_wr & rom_ready;
  assign push_acc = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;
  assign mod_sel  = mod_q;

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_acc),
    .push_dat ({dn_addr[ROM_ADDR_W-1:0], dn_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .nxt_vld  (nxt_vld),
    .nxt_dat  (nxt_dat)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:  if (cnt == CW'(HOLD_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN:   if (!fifo_empty) state_nxt = ST_DRAIN;
      ST_LOAD:  if (fall) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !push_acc) state_nxt = ST_HOLD;
      default:  state_nxt = ST_HOLD;
    endcase
    if (rise) state_nxt = ST_LOAD;
  end

  // dl_q clears in reset so a download still active at release is seen as a new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      dl_q       <= 1'b0;
      core_reset <= 1'b1;
      overflow   <= 1'b0;
      wr_count   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= (state == ST_HOLD && state_nxt == ST_HOLD) ? cnt + CW'(1) : '0;
      dl_q       <= dn_download;
      core_reset <= (state_nxt != ST_RUN);
      overflow   <= (overflow & ~rise) | drop;
      if (rise) begin
        wr_count <= {16'd0, push_acc};
      end else if (push_acc && wr_count != WR_MAX) begin
        wr_count <= wr_count + 17'd1;
      end
    end
  end

  // Output stage mirrors the FIFO head, so it holds steady while the port stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      rom_wr <= nxt_vld;
      if (nxt_vld) begin
        rom_addr <= nxt_dat[ENTRY_W-1:8];
        rom_data <= nxt_dat[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dn_wr && dn_index == IDX_MOD) mod_q <= dn_data;
  end

endmodule

// File: tb/tb_dl_sequencer.sv
// Bench for dl_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_dl_sequencer;

  localparam int HOLD  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        rom_ready;
  logic        rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic [7:0]  mod_sel;
  logic        overflow;
  logic [16:0] wr_count;

  dl_sequencer #(
    .HOLD_CYCLES (HOLD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_index    (dn_index),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .rom_ready   (rom_ready),
    .rom_wr      (rom_wr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .core_reset  (core_reset),
    .mod_sel     (mod_sel),
    .overflow    (overflow),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes waiting for the ROM port, download/drain/run flags,
  // and the number of cycles spent so far in the post-download hold.
  logic [23:0] q[$];
  bit          m_load  = 0;
  bit          m_drain = 0;
  bit          m_run   = 0;
  int          m_hold  = 0;
  bit          m_prev  = 0;
  bit          m_ovf   = 0;
  int          m_cnt   = 0;
  logic [7:0]  m_mod   = 8'h00;
  bit          m_valid = 0;

  int n_pops = 0;
  bit obs_cr;

  function automatic bit in_hold();
    return !m_load && !m_drain && !m_run;
  endfunction

  task automatic model_step();
    bit was_empty, pop, preq, acc, rise, fall;
    if (reset) begin
      q.delete();
      m_load  = 0;
      m_drain = 0;
      m_run   = 0;
      m_hold  = 0;
      m_prev  = 0;
      m_ovf   = 0;
      m_cnt   = 0;
    end else begin
      was_empty = (q.size() == 0);
      pop  = !was_empty && rom_ready;
      preq = dn_wr && dn_index == 8'd0 && dn_addr < 25'h10000;
      acc  = preq && (q.size() < DEPTH || pop);
      rise = dn_download && !m_prev;
      fall = !dn_download && m_prev;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({dn_addr[15:0], dn_data});
      if (rise) begin
        m_ovf = preq && !acc;
        m_cnt = acc ? 1 : 0;
      end else begin
        if (preq && !acc) m_ovf = 1;
        if (acc && m_cnt < 65536) m_cnt++;
      end
      if (rise) begin
        m_load = 1; m_drain = 0; m_run = 0;
      end else if (m_load) begin
        if (fall) begin m_load = 0; m_drain = 1; end
      end else if (m_drain) begin
        if (was_empty && !acc) begin m_drain = 0; m_hold = 0; end
      end else if (m_run) begin
        if (!was_empty) begin m_run = 0; m_drain = 1; end
      end else begin
        m_hold++;
        if (m_hold == HOLD) m_run = 1;
      end
      m_prev = dn_download;
    end
    if (dn_wr && dn_index == 8'd1) m_mod = dn_data;
    m_valid = 1;
  endtask

  task automatic check_outputs();
    if (m_valid) begin
      check("rom_wr", 32'(rom_wr), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("rom_addr", 32'(rom_addr), 32'(q[0][23:8]));
        check("rom_data", 32'(rom_data), 32'(q[0][7:0]));
      end
      check("core_reset", 32'(core_reset), 32'(!m_run));
      check("mod_sel", 32'(mod_sel), 32'(m_mod));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (rom_wr === 1'b1 && rom_ready) n_pops++;
    obs_cr = core_reset;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Runs until core_reset is observed low; returns how many cycles it was high.
  task automatic wait_run(input string tag, input int budget, output int hi);
    hi = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (obs_cr !== 1'b1) break;
      hi++;
    end
    if (obs_cr === 1'b1) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  int n;
  int rdy_pct;

  initial begin
    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_index = 8'd0;
    dn_addr = '0; dn_data = 8'd0; rom_ready = 1'b1;
    repeat (3) cycle();
    check("rst_rom_wr", 32'(rom_wr), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_wr_count", 32'(wr_count), 32'd0);

    // Reset release: hold for exactly HOLD cycles.
    reset = 1'b0;
    wait_run("hold_len", 100, n);
    check("hold_len", 32'(n), 32'(HOLD));

    // Four-byte download with a ready port.
    n_pops = 0;
    dn_download = 1'b1; cycle();
    for (int i = 0; i < 4; i++) begin
      dn_wr = 1'b1; dn_addr = 25'(i); dn_data = 8'hA0 + 8'(i); cycle();
    end
    dn_wr = 1'b0; dn_download = 1'b0;
    wait_run("dl4", 100, n);
    check("dl4_pops", 32'(n_pops), 32'd4);
    check("dl4_count", 32'(wr_count), 32'd4);

    // Stalled port: six bytes offered, four fit, overflow sticks.
    rom_ready = 1'b0;
    dn_download = 1'b1; cycle();
    for (int i = 0; i < 6; i++) begin
      dn_wr = 1'b1; dn_addr = 25'h100 + 25'(i); dn_data = 8'(i); cycle();
    end
    dn_wr = 1'b0;
    repeat (3) cycle();
    check("stall_ovf", 32'(overflow), 32'd1);
    check("stall_addr", 32'(rom_addr), 32'h100);
    n_pops = 0; rom_ready = 1'b1;
    repeat (8) cycle();
    check("stall_pops", 32'(n_pops), 32'd4);
    check("stall_count", 32'(wr_count), 32'd4);

    // Re-download while the hold counter sits at 8.
    dn_download = 1'b0;
    for (int i = 0; i < 100 && !(in_hold() && m_hold == 8); i++) cycle();
    check("reload_reached", 32'(in_hold() && m_hold == 8), 32'd1);
    dn_download = 1'b1; cycle();
    check("reload_cr", 32'(core_reset), 32'd1);
    check("reload_ovf", 32'(overflow), 32'd0);
    cycle();
    dn_download = 1'b0;
    wait_run("reload", 100, n);

    // Variant byte: last write wins, nothing reaches the ROM port.
    n_pops = 0;
    dn_download = 1'b1; cycle();
    dn_wr = 1'b1; dn_index = 8'd1; dn_data = 8'h03; cycle();
    dn_data = 8'h05; cycle();
    dn_wr = 1'b0; dn_index = 8'd0; dn_download = 1'b0;
    wait_run("mod", 100, n);
    check("mod_sel_last", 32'(mod_sel), 32'h05);
    check("mod_no_rom", 32'(n_pops), 32'd0);

    // Addresses at and above 64 KiB are ignored silently.
    dn_download = 1'b1; cycle();
    dn_wr = 1'b1; dn_addr = 25'h10000; dn_data = 8'h77; cycle();
    dn_addr = 25'h1FFFFFF; cycle();
    dn_wr = 1'b0; cycle();
    check("hiaddr_count", 32'(wr_count), 32'd0);
    check("hiaddr_ovf", 32'(overflow), 32'd0);
    check("hiaddr_wr", 32'(rom_wr), 32'd0);
    dn_download = 1'b0;
    wait_run("hiaddr", 100, n);

    // Reset in the middle of a stalled load discards the buffer and reloads.
    rom_ready = 1'b0;
    dn_download = 1'b1; cycle();
    for (int i = 0; i < 2; i++) begin
      dn_wr = 1'b1; dn_addr = 25'h20 + 25'(i); dn_data = 8'h50 + 8'(i); cycle();
    end
    dn_wr = 1'b0; reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    check("rstload_wr", 32'(rom_wr), 32'd0);
    check("rstload_cr", 32'(core_reset), 32'd1);
    rom_ready = 1'b1; dn_download = 1'b0;
    wait_run("rstload", 100, n);

    // Random traffic.
    for (int blk = 0; blk < 20; blk++) begin
      rdy_pct = $urandom_range(0, 100);
      for (int k = 0; k < 200; k++) begin
        int r;
        reset = ($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 39) == 0) dn_download = ~dn_download;
        dn_wr = $urandom_range(0, 1) != 0;
        r = $urandom_range(0, 9);
        dn_index = (r < 7) ? 8'd0 : (r < 9) ? 8'd1 : 8'($urandom_range(2, 255));
        dn_addr = ($urandom_range(0, 15) == 0) ? 25'($urandom_range(65536, 33554431))
                                               : 25'($urandom_range(0, 65535));
        dn_data = 8'($urandom);
        rom_ready = ($urandom_range(0, 99) < rdy_pct);
        cycle();
      end
    end
    reset = 1'b0; dn_wr = 1'b0; dn_download = 1'b0; rom_ready = 1'b1;
    wait_run("rand_end", 200, n);

    // Byte counter saturation.
    dn_download = 1'b1; cycle();
    dn_wr = 1'b1; dn_index = 8'd0;
    for (int i = 0; i < 65540; i++) begin
      dn_addr = 25'(i & 32'hFFFF); dn_data = 8'(i); cycle();
    end
    dn_wr = 1'b0; cycle();
    check("wr_sat", 32'(wr_count), 32'h10000);
    dn_download = 1'b0;
    wait_run("sat", 100, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
